fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised instruction-fetch stage with a prefetch queue, sitting between the synchronous instruction memory and decode. It generates word addresses, decouples memory latency from decode stalls with a QDEPTH-entry queue, and supports taken-branch/jump redirect with flush of queued and in-flight instructions. It presents the head instruction to decode together with its PC and pre-extracted rs1/rs2 fields. Decode uses a valid/ready handshake, so holding d_ready low replaces the old pcwr stall.

## Interface
- PC_W, 12: word-address width; PC wraps modulo 2^PC_W
- INST_W, 32: instruction width, minimum 25
- QDEPTH, 4: queue entries; power of 2, ≥2
- RESET_PC, 0: first fetch address after reset
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- f_redirect  input  1  load f_target into the PC and flush; priority over everything except rst
- f_target  input  PC_W  redirect address
- imem_en  output  1  read request this cycle
- imem_addr  output  PC_W  read address, valid when imem_en=1
- imem_rdata  input  INST_W  read data, valid exactly one cycle after imem_en
- d_valid  output  1  head entry valid
- d_ready  input  1  decode accepts head
- d_inst  output  INST_W  head instruction
- d_pc  output  PC_W  head PC
- d_rs1  output  5  d_inst[19:15]
- d_rs2  output  5  d_inst[24:20]
- q_count  output  $clog2(QDEPTH)+1  current queue occupancy

## Operation
- State:
  - pc: next address to fetch.
  - inflight / inflight_pc: one outstanding read and its address.
  - kill: drop the returning response.
  - queue: FIFO of {inst, pc} pairs.
- Issue:
  - imem_en = !rst && !f_redirect && (count + inflight − pop) < QDEPTH, where pop = d_valid && d_ready.
  - imem_addr = pc.
  - On issue, pc ← pc+1 (wraps at 2^PC_W−1 → 0), inflight ← 1, inflight_pc ← pc.
  - No issue leaves inflight ← 0.
- Return: in the cycle after an issue, if kill=0, push {imem_rdata, inflight_pc} into the queue.
- Pop: on d_valid && d_ready, the head is consumed.
  - Push and pop in the same cycle are both performed.
  - The issue rule guarantees push never occurs when the queue is full.
- Redirect (f_redirect=1 in cycle N):
  - A handshake occurring in cycle N still completes.
  - Any response arriving in cycle N is discarded.
  - End of N: pc ← f_target, queue emptied, inflight ← 0.
  - No issue in cycle N.
- Back-to-back redirects: the last one wins. Each flushes again.
- Empty queue: d_valid=0, and d_inst, d_pc, d_rs1, d_rs2 are forced to 0.
- Full queue with d_ready=0: imem_en=0 and pc holds. No data is lost or duplicated.

## Timing
- Reset values: pc=RESET_PC, queue empty, inflight=0, d_valid=0, d_inst/d_pc/d_rs1/d_rs2=0, q_count=0, imem_en=0 while rst=1.
- Reset asserted mid-operation: clears everything at the next edge. A pending response is dropped.
- Reset release to first valid:
  - First cycle with rst=0 (C0): imem_en=1, imem_addr=RESET_PC.
  - Data is pushed at the end of C1.
  - d_valid=1 in C2.
- Redirect latency:
  - Redirect in cycle N: d_valid=0 in N+1 and N+2.
  - Fetch of f_target is issued in N+1.
  - d_valid=1 with d_pc=f_target in N+3.
- Throughput: with d_ready held high, one instruction per cycle sustained for any QDEPTH≥2.
- Stall recovery: d_ready rising after the queue is full delivers one instruction per cycle with no bubble.

## Structure
- Package fetch_pkg holds:
  - RS1_LSB=15, RS2_LSB=20, REG_W=5.
  - A typedef for the queue entry {inst, pc}.
- Sub-module fetch_fifo:
  - Synchronous FIFO with push, pop and flush.
  - Wrapping read/write pointers plus a count register.
  - Parametrised by width and depth.
- Issue, redirect and kill logic live in fetch_queue.

## Test plan
- Reset, d_ready=1, imem holding word i at address i:
  - d_valid rises 2 cycles after reset release.
  - d_pc sequence 0,1,2,… one per cycle, d_inst matching.
- Imem[5]=0x00B50533: when d_pc=5, d_rs1=10 and d_rs2=11.
- QDEPTH=4, d_ready=0 for 10 cycles:
  - q_count saturates at 4 and imem_en drops.
  - On releasing d_ready, PCs continue in order with no gap or duplicate.
- f_redirect with f_target=0x100 while the queue holds 3 entries and a read is in flight:
  - d_valid=0 for 2 cycles.
  - Next d_pc=0x100, followed by 0x101.
  - None of the old PCs reappear.
- RESET_PC=0xFFE, PC_W=12, free-running: PCs 0xFFE, 0xFFF, 0x000, 0x001.
- rst asserted for 1 cycle mid-stream with a read in flight:
  - All outputs return to reset values.
  - The stale response is not enqueued.
  - Fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_pkg;

  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int REG_W   = 5;

  localparam int DEF_INST_W = 32;
  localparam int DEF_PC_W   = 12;

  // Queue entry at the default widths; parametrised instances pack {inst, pc} the same way.
  typedef struct packed {
    logic [DEF_INST_W-1:0] inst;
    logic [DEF_PC_W-1:0]   pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Memory, decode and redirect signals of the fetch stage; master is the fetch stage itself.
interface fetch_queue_if
  import fetch_pkg::*;
#(
  parameter int PC_W   = 12,
  parameter int INST_W = 32,
  parameter int QDEPTH = 4
) ();

  localparam int CNT_W = $clog2(QDEPTH) + 1;

  logic              f_redirect;
  logic [PC_W-1:0]   f_target;
  logic              imem_en;
  logic [PC_W-1:0]   imem_addr;
  logic [INST_W-1:0] imem_rdata;
  logic              d_valid;
  logic              d_ready;
  logic [INST_W-1:0] d_inst;
  logic [PC_W-1:0]   d_pc;
  logic [REG_W-1:0]  d_rs1;
  logic [REG_W-1:0]  d_rs2;
  logic [CNT_W-1:0]  q_count;

  modport master (
    input  f_redirect, f_target, imem_rdata, d_ready,
    output imem_en, imem_addr, d_valid, d_inst, d_pc, d_rs1, d_rs2, q_count
  );

  modport slave (
    output f_redirect, f_target, imem_rdata, d_ready,
    input  imem_en, imem_addr, d_valid, d_inst, d_pc, d_rs1, d_rs2, q_count
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with push, pop and flush; wrapping pointers plus an occupancy count.
module fetch_fifo #(
  parameter int WIDTH = 44,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: address generation, one outstanding read, prefetch queue and redirect flush.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 12,
  parameter int              INST_W   = 32,
  parameter int              QDEPTH   = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master bus
);

  localparam int CNT_W = $clog2(QDEPTH) + 1;
  localparam int ENT_W = INST_W + PC_W;

  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   inflight_pc;
  logic              inflight;
  logic              kill;
  logic [CNT_W-1:0]  count;
  logic [ENT_W-1:0]  head;
  logic [ENT_W-1:0]  push_data;
  logic [CNT_W:0]    occupancy;
  logic              d_valid;
  logic              pop;
  logic              push;
  logic              issue;
  logic [INST_W-1:0] d_inst;

  assign d_valid = !rst && (count != '0);
  assign pop     = d_valid && bus.d_ready;

  // Slots committed after this cycle: queued + the read coming back - the one leaving.
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, pop};
  assign issue     = !rst && !bus.f_redirect && (occupancy < (CNT_W+1)'(QDEPTH));

  assign push      = inflight && !kill && !bus.f_redirect && !rst;
  assign push_data = {bus.imem_rdata, inflight_pc};

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      kill        <= 1'b0;
    end else if (bus.f_redirect) begin
      pc       <= bus.f_target;
      inflight <= 1'b0;
      kill     <= 1'b1;
    end else begin
      inflight <= issue;
      kill     <= 1'b0;
      if (issue) begin
        pc          <= pc + PC_W'(1);
        inflight_pc <= pc;
      end
    end
  end

  fetch_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (bus.f_redirect),
    .push  (push),
    .pop   (pop),
    .din   (push_data),
    .dout  (head),
    .count (count)
  );

  assign d_inst        = d_valid ? head[ENT_W-1:PC_W] : '0;
  assign bus.d_inst    = d_inst;
  assign bus.d_pc      = d_valid ? head[PC_W-1:0] : '0;
  assign bus.d_rs1     = d_inst[RS1_LSB +: REG_W];
  assign bus.d_rs2     = d_inst[RS2_LSB +: REG_W];
  assign bus.d_valid   = d_valid;
  assign bus.imem_en   = issue;
  assign bus.imem_addr = pc;
  assign bus.q_count   = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: cycle table, stall/reset sequences, then random traffic against an in-order PC scoreboard.
module tb_fetch_queue;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_if #(.PC_W(12), .INST_W(32), .QDEPTH(4)) bus  ();
  fetch_queue_if #(.PC_W(12), .INST_W(32), .QDEPTH(4)) bus2 ();

  fetch_queue #(.PC_W(12), .INST_W(32), .QDEPTH(4), .RESET_PC(12'h000)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );

  fetch_queue #(.PC_W(12), .INST_W(32), .QDEPTH(4), .RESET_PC(12'hFFE)) dut_wrap (
    .clk (clk), .rst (rst), .bus (bus2)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] word(input logic [11:0] a);
    if (a == 12'd5) return 32'h00B50533;
    return {8'hC3, 12'h000, a};
  endfunction

  // Synchronous instruction memories: data one cycle after the request, garbage otherwise.
  always @(posedge clk) begin
    bus.imem_rdata  <= bus.imem_en  ? word(bus.imem_addr)  : 32'hDEADBEEF;
    bus2.imem_rdata <= bus2.imem_en ? word(bus2.imem_addr) : 32'hDEADBEEF;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: decode must see consecutive PCs from the last reset/redirect target.
  logic [11:0]  exp_pc = 12'h000;
  int           since_redir = 0;
  int           starve = 0;
  bit           sb_on = 1'b0;
  fetch_entry_t exp_ent;

  always @(negedge clk) begin
    if (sb_on) begin
      if (bus.d_valid && bus.d_ready) begin
        exp_ent = '{inst: word(exp_pc), pc: exp_pc};
        chk("sb_pc",   bus.d_pc,   exp_ent.pc);
        chk("sb_inst", bus.d_inst, exp_ent.inst);
        chk("sb_rs1",  bus.d_rs1,  exp_ent.inst[19:15]);
        chk("sb_rs2",  bus.d_rs2,  exp_ent.inst[24:20]);
        if (exp_pc == 12'd5) begin
          chk("rs1_pc5", bus.d_rs1, 5'd10);
          chk("rs2_pc5", bus.d_rs2, 5'd11);
        end
        exp_pc = exp_pc + 12'd1;
      end
      if (since_redir == 1 || since_redir == 2) chk("redir_bubble", bus.d_valid, 1'b0);
      if (bus.f_redirect) chk("no_issue_on_redir", bus.imem_en, 1'b0);
      if (rst) chk("no_issue_in_rst", bus.imem_en, 1'b0);
      if (bus.q_count > 3'd4) chk("qcount_bound", bus.q_count, 3'd4);
      if (rst || bus.f_redirect) starve = 0;
      else if (bus.d_ready && !bus.d_valid) starve++;
      else starve = 0;
      if (starve > 2) begin
        chk("starve", 1'b1, 1'b0);
        starve = 0;
      end
      if (rst) begin
        exp_pc = 12'h000;
        since_redir = 0;
      end else if (bus.f_redirect) begin
        exp_pc = bus.f_target;
        since_redir = 1;
      end else if (since_redir != 0) begin
        since_redir = (since_redir == 2) ? 0 : since_redir + 1;
      end
    end
  end

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [11:0] tgt;
    logic        en;
    logic [11:0] addr;
    logic        vld;
    logic [11:0] pc;
    logic [2:0]  cnt;
  } vec_t;

  vec_t tbl [15];

  initial begin
    // Cycles after reset release: fill, stall to full, recover, redirect to 0x100.
    tbl[0]  = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h000, 1'b0, 12'h000, 3'd0};
    tbl[1]  = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h001, 1'b0, 12'h000, 3'd0};
    tbl[2]  = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h002, 1'b1, 12'h000, 3'd1};
    tbl[3]  = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h003, 1'b1, 12'h001, 3'd1};
    tbl[4]  = '{1'b0, 1'b0, 12'h000, 1'b1, 12'h004, 1'b1, 12'h002, 3'd1};
    tbl[5]  = '{1'b0, 1'b0, 12'h000, 1'b1, 12'h005, 1'b1, 12'h002, 3'd2};
    tbl[6]  = '{1'b0, 1'b0, 12'h000, 1'b0, 12'h006, 1'b1, 12'h002, 3'd3};
    tbl[7]  = '{1'b0, 1'b0, 12'h000, 1'b0, 12'h006, 1'b1, 12'h002, 3'd4};
    tbl[8]  = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h006, 1'b1, 12'h002, 3'd4};
    tbl[9]  = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h007, 1'b1, 12'h003, 3'd3};
    tbl[10] = '{1'b1, 1'b1, 12'h100, 1'b0, 12'h008, 1'b1, 12'h004, 3'd3};
    tbl[11] = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h100, 1'b0, 12'h000, 3'd0};
    tbl[12] = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h101, 1'b0, 12'h000, 3'd0};
    tbl[13] = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h102, 1'b1, 12'h100, 3'd1};
    tbl[14] = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h103, 1'b1, 12'h101, 3'd1};

    bus.d_ready     = 1'b1;
    bus.f_redirect  = 1'b0;
    bus.f_target    = 12'h000;
    bus2.d_ready    = 1'b1;
    bus2.f_redirect = 1'b0;
    bus2.f_target   = 12'h000;
    rst             = 1'b1;
    sb_on           = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      bus.d_ready    = tbl[i].rdy;
      bus.f_redirect = tbl[i].redir;
      bus.f_target   = tbl[i].tgt;
      @(negedge clk);
      chk($sformatf("t%0d_en", i),  bus.imem_en, tbl[i].en);
      if (tbl[i].en) chk($sformatf("t%0d_addr", i), bus.imem_addr, tbl[i].addr);
      chk($sformatf("t%0d_vld", i), bus.d_valid, tbl[i].vld);
      chk($sformatf("t%0d_pc", i),  bus.d_pc,    tbl[i].pc);
      chk($sformatf("t%0d_cnt", i), bus.q_count, tbl[i].cnt);
      if (!tbl[i].vld) chk($sformatf("t%0d_inst0", i), bus.d_inst, 32'h0);
      if (i >= 2 && i <= 5) begin
        chk($sformatf("wrap%0d_vld", i), bus2.d_valid, 1'b1);
        chk($sformatf("wrap%0d_pc", i),  bus2.d_pc,    12'(12'hFFE + 12'(i - 2)));
      end
      @(posedge clk);
      #1;
    end
    bus.f_redirect = 1'b0;

    // Ten-cycle decode stall, then recovery without bubbles.
    bus.d_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 9) begin
        chk("stall_full", bus.q_count, 3'd4);
        chk("stall_no_issue", bus.imem_en, 1'b0);
      end
      @(posedge clk);
      #1;
    end
    bus.d_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("recover%0d_vld", i), bus.d_valid, 1'b1);
      @(posedge clk);
      #1;
    end

    // One-cycle reset with a read outstanding.
    bus.d_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rst_inflight_before", bus.d_valid, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_c0_en",   bus.imem_en,   1'b1);
    chk("rst_c0_addr", bus.imem_addr, 12'h000);
    chk("rst_c0_vld",  bus.d_valid,   1'b0);
    chk("rst_c0_cnt",  bus.q_count,   3'd0);
    chk("rst_c0_inst", bus.d_inst,    32'h0);
    chk("rst_c0_rs1",  bus.d_rs1,     5'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_c1_cnt", bus.q_count, 3'd0);
    chk("rst_c1_vld", bus.d_valid, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_c2_vld", bus.d_valid, 1'b1);
    chk("rst_c2_pc",  bus.d_pc,    12'h000);
    @(posedge clk);
    #1;

    // Random decode backpressure, redirects and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      bus.d_ready    = ($urandom_range(0, 3) != 0);
      bus.f_redirect = ($urandom_range(0, 31) == 0);
      bus.f_target   = 12'($urandom_range(0, 4095));
      rst            = ($urandom_range(0, 299) == 0);
      @(posedge clk);
      #1;
    end
    rst            = 1'b0;
    bus.f_redirect = 1'b0;
    bus.d_ready    = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
